// File: rtl/debug_mem_pkg.sv
// Shared definitions for the cache debug-port master: FSM encodings, opcode fields, response bytes.
// Optional burst support is compiled in with `define DEBUG_MEM_BURST_EN.
package debug_mem_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_ADDR = 3'd1;
  localparam state_t S_DATA = 3'd2;
  localparam state_t S_WR   = 3'd3;
  localparam state_t S_RD   = 3'd4;
  localparam state_t S_RESP = 3'd5;
  localparam state_t S_ERR  = 3'd6;

  localparam int OP_WR_BIT    = 0;
  localparam int OP_IC_BIT    = 1;
  localparam int OP_RSV_LSB   = 2;
  localparam int OP_BURST_LSB = 4;

  localparam logic [7:0] ACK = 8'hA5;
  localparam logic [7:0] ERR = 8'hEE;
  localparam int WORD_BYTES  = 4;

  // A nonzero burst field is only meaningful when burst support is built in.
  function automatic logic op_legal(input logic [7:0] op);
    logic ok;
    ok = (op[OP_RSV_LSB +: 2] == 2'b00);
`ifndef DEBUG_MEM_BURST_EN
    ok = ok && (op[OP_BURST_LSB +: 4] == 4'h0);
`endif
    return ok;
  endfunction

endpackage

// File: rtl/debug_mem_if.sv
// Byte-serial command/response streams plus the data- and instruction-cache debug ports.
interface debug_mem_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] dc_a2;
  logic [31:0] dc_wd2;
  logic [3:0]  dc_we2;
  logic [31:0] dc_rd2;
  logic [31:0] ic_a2;
  logic [31:0] ic_wd2;
  logic [3:0]  ic_we2;
  logic [31:0] ic_rd2;

  modport master (
    input  rx_data, rx_valid, tx_ready, dc_rd2, ic_rd2,
    output rx_ready, tx_data, tx_valid,
    output dc_a2, dc_wd2, dc_we2, ic_a2, ic_wd2, ic_we2
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, dc_rd2, ic_rd2,
    input  rx_ready, tx_data, tx_valid,
    input  dc_a2, dc_wd2, dc_we2, ic_a2, ic_wd2, ic_we2
  );
endinterface

// File: rtl/debug_byte_shifter.sv
// 4-byte little-endian shift register: assembles incoming bytes or serializes a loaded word LSB first.
module debug_byte_shifter
  import debug_mem_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clr,
  input  logic        i_load,
  input  logic        i_shift,
  input  logic [7:0]  i_byte,
  input  logic [31:0] i_word,
  output logic [31:0] o_word,
  output logic        o_last
);

  logic [31:0] r_word;
  logic [1:0]  r_cnt;

  // The 2-bit counter wraps after the fourth byte, so back-to-back words need no explicit clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_word <= '0;
      r_cnt  <= '0;
    end else if (i_load) begin
      r_word <= i_word;
      r_cnt  <= '0;
    end else if (i_shift) begin
      r_word <= {i_byte, r_word[31:8]};
      r_cnt  <= r_cnt + 2'd1;
    end else if (i_clr) begin
      r_cnt  <= '0;
    end
  end

  assign o_word = r_word;
  assign o_last = (r_cnt == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/debug_mem_master.sv
// Byte-serial debug initiator driving the data/instruction cache debug ports (A2/WD2/WE2/RD2).
// Define DEBUG_MEM_BURST_EN to enable multi-word bursts via opcode bits[7:4].
module debug_mem_master
  import debug_mem_pkg::*;
#(
  parameter int READ_LAT     = 1,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  debug_mem_if.master bus,
  output logic        o_busy
);

  localparam logic [2:0]  LAT_M1 = 3'(READ_LAT - 1);
  localparam logic [31:0] TMO    = 32'(IDLE_TIMEOUT);

  state_t      r_state;
  logic        r_op_wr, r_op_ic;
  logic [3:0]  r_burst;
  logic [31:0] r_addr, r_tmo;
  logic [2:0]  r_lat;
  logic [7:0]  r_tx_data;
  logic        r_tx_valid;
  logic [1:0]  r_tx_cnt;
  logic [31:0] r_dc_a2, r_dc_wd2, r_ic_a2, r_ic_wd2;
  logic [3:0]  r_dc_we2, r_ic_we2;

  logic        w_rx_acc, w_tx_acc, w_lat_done, w_tmo_hit;
  logic        w_sh_clr, w_sh_load, w_sh_shift, w_sh_last;
  logic [7:0]  w_sh_byte;
  logic [31:0] w_sh_word, w_word_in, w_next_addr, w_rd2;

  assign bus.rx_ready = (r_state == S_IDLE) || (r_state == S_ADDR) || (r_state == S_DATA);
  assign w_rx_acc     = bus.rx_valid && bus.rx_ready;
  assign w_tx_acc     = r_tx_valid && bus.tx_ready;
  assign w_lat_done   = (r_lat == LAT_M1);
  assign w_tmo_hit    = (TMO != 32'd0) && (r_tmo + 32'd1 == TMO);
  assign w_word_in    = {bus.rx_data, w_sh_word[31:8]};
  assign w_next_addr  = r_addr + 32'd4;
  assign w_rd2        = r_op_ic ? bus.ic_rd2 : bus.dc_rd2;

  assign w_sh_clr   = (r_state == S_IDLE) && w_rx_acc;
  assign w_sh_load  = (r_state == S_RD) && w_lat_done;
  assign w_sh_shift = (((r_state == S_ADDR) || (r_state == S_DATA)) && w_rx_acc) ||
                      ((r_state == S_RESP) && w_tx_acc);
  assign w_sh_byte  = (r_state == S_RESP) ? 8'h00 : bus.rx_data;

  debug_byte_shifter u_shifter (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_sh_clr),
    .i_load  (w_sh_load),
    .i_shift (w_sh_shift),
    .i_byte  (w_sh_byte),
    .i_word  (w_rd2),
    .o_word  (w_sh_word),
    .o_last  (w_sh_last)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_op_wr    <= 1'b0;
      r_op_ic    <= 1'b0;
      r_burst    <= '0;
      r_addr     <= '0;
      r_tmo      <= '0;
      r_lat      <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_tx_cnt   <= '0;
      r_dc_a2    <= '0;
      r_dc_wd2   <= '0;
      r_dc_we2   <= '0;
      r_ic_a2    <= '0;
      r_ic_wd2   <= '0;
      r_ic_we2   <= '0;
    end else begin
      // Write enables are single-cycle pulses that only the WR state sees.
      r_dc_we2 <= '0;
      r_ic_we2 <= '0;
      case (r_state)
        S_IDLE: if (w_rx_acc) begin
          r_tmo <= '0;
          if (op_legal(bus.rx_data)) begin
            r_op_wr <= bus.rx_data[OP_WR_BIT];
            r_op_ic <= bus.rx_data[OP_IC_BIT];
`ifdef DEBUG_MEM_BURST_EN
            r_burst <= bus.rx_data[OP_BURST_LSB +: 4];
`else
            r_burst <= '0;
`endif
            r_state <= S_ADDR;
          end else begin
            r_tx_data  <= ERR;
            r_tx_valid <= 1'b1;
            r_state    <= S_ERR;
          end
        end
        S_ADDR, S_DATA: begin
          if (w_rx_acc) begin
            r_tmo <= '0;
            if (w_sh_last && (r_state == S_ADDR)) begin
              r_addr <= w_word_in;
              if (r_op_wr) begin
                r_state <= S_DATA;
              end else begin
                if (r_op_ic) r_ic_a2 <= w_word_in;
                else         r_dc_a2 <= w_word_in;
                r_lat   <= '0;
                r_state <= S_RD;
              end
            end else if (w_sh_last) begin
              if (r_op_ic) begin
                r_ic_a2  <= r_addr;
                r_ic_wd2 <= w_word_in;
                r_ic_we2 <= 4'hF;
              end else begin
                r_dc_a2  <= r_addr;
                r_dc_wd2 <= w_word_in;
                r_dc_we2 <= 4'hF;
              end
              r_state <= S_WR;
            end
          end else if (w_tmo_hit) begin
            r_tmo   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_tmo <= r_tmo + 32'd1;
          end
        end
        S_WR: begin
          if (r_burst != 4'd0) begin
            r_burst <= r_burst - 4'd1;
            r_addr  <= w_next_addr;
            r_tmo   <= '0;
            r_state <= S_DATA;
          end else begin
            r_tx_data  <= ACK;
            r_tx_valid <= 1'b1;
            r_tx_cnt   <= '0;
            r_state    <= S_RESP;
          end
        end
        S_RD: begin
          if (w_lat_done) begin
            r_tx_data  <= w_rd2[7:0];
            r_tx_valid <= 1'b1;
            r_tx_cnt   <= 2'(WORD_BYTES - 1);
            r_state    <= S_RESP;
          end else begin
            r_lat <= r_lat + 3'd1;
          end
        end
        S_RESP: if (w_tx_acc) begin
          if (r_tx_cnt != 2'd0) begin
            r_tx_cnt  <= r_tx_cnt - 2'd1;
            r_tx_data <= w_sh_word[15:8];
          end else begin
            r_tx_valid <= 1'b0;
            if (!r_op_wr && (r_burst != 4'd0)) begin
              r_burst <= r_burst - 4'd1;
              r_addr  <= w_next_addr;
              if (r_op_ic) r_ic_a2 <= w_next_addr;
              else         r_dc_a2 <= w_next_addr;
              r_lat   <= '0;
              r_state <= S_RD;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_ERR: if (w_tx_acc) begin
          r_tx_valid <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.tx_data  = r_tx_data;
  assign bus.tx_valid = r_tx_valid;
  assign bus.dc_a2    = r_dc_a2;
  assign bus.dc_wd2   = r_dc_wd2;
  assign bus.dc_we2   = r_dc_we2;
  assign bus.ic_a2    = r_ic_a2;
  assign bus.ic_wd2   = r_ic_wd2;
  assign bus.ic_we2   = r_ic_we2;
  assign o_busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_debug_mem_master.sv
// Scoreboard bench for debug_mem_master (READ_LAT=2, IDLE_TIMEOUT=16); honours DEBUG_MEM_BURST_EN.
module tb_debug_mem_master;

  typedef struct packed {
    logic        ic;
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  logic clk;
  logic rst_n;
  logic busy;
  int   n_cmp  = 0;
  int   n_fail = 0;

  logic [7:0] exp_tx[$];
  wr_t        exp_wr[$];

  debug_mem_if bus();

  debug_mem_master #(.READ_LAT(2), .IDLE_TIMEOUT(16)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus),
    .o_busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] dc_model(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] ic_model(input logic [31:0] a);
    return (a == 32'h40) ? 32'hDEAD_BEEF : ~a;
  endfunction

  // Synchronous-read memory: data is valid one cycle after the address, i.e. READ_LAT=2.
  always @(posedge clk) begin
    bus.dc_rd2 <= dc_model(bus.dc_a2);
    bus.ic_rd2 <= ic_model(bus.ic_a2);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Response monitor: every tx handshake must match the head of the expected byte queue.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.tx_valid && bus.tx_ready) begin
        n_cmp++;
        if (exp_tx.size() == 0) begin
          n_fail++;
          $display("FAIL tx_unexpected: got %h expected nothing", bus.tx_data);
        end else begin
          e = exp_tx.pop_front();
          if (bus.tx_data !== e) begin
            n_fail++;
            $display("FAIL tx_byte: got %h expected %h", bus.tx_data, e);
          end
        end
      end
    end
  end

  // Write monitor: every cycle with a nonzero we2 must match the head of the expected write queue.
  initial begin
    wr_t         e;
    logic [71:0] act, exp;
    forever begin
      @(negedge clk);
      if (rst_n && (bus.dc_we2 != 4'h0 || bus.ic_we2 != 4'h0)) begin
        act = {bus.dc_we2, bus.ic_we2,
               (bus.dc_we2 != 4'h0) ? bus.dc_a2  : bus.ic_a2,
               (bus.dc_we2 != 4'h0) ? bus.dc_wd2 : bus.ic_wd2};
        n_cmp++;
        if (exp_wr.size() == 0) begin
          n_fail++;
          $display("FAIL wr_unexpected: got %h expected nothing", act);
        end else begin
          e   = exp_wr.pop_front();
          exp = {e.ic ? 4'h0 : 4'hF, e.ic ? 4'hF : 4'h0, e.a, e.d};
          if (act !== exp) begin
            n_fail++;
            $display("FAIL wr_pulse: got %h expected %h", act, exp);
          end
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bit ok = 1'b0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.rx_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin n_cmp++; n_fail++; $display("FAIL rx_accept: got no rx_ready for byte %h", b); end
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) exp_tx.push_back(w[8*i +: 8]);
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy && exp_tx.size() == 0 && exp_wr.size() == 0) begin ok = 1'b1; break; end
    end
    check(name, {63'd0, ok}, 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic take_byte(input int stall, input logic [7:0] exp);
    bit seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.tx_valid) begin seen = 1'b1; break; end
    end
    check("bp_wait_valid", {63'd0, seen}, 64'd1);
    for (int s = 0; s < stall; s++) begin
      check("bp_hold", {55'd0, bus.tx_valid, bus.tx_data}, {55'd0, 1'b1, exp});
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus.tx_ready = 1'b1;
    @(posedge clk); #1;
    bus.tx_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    bit          seen;
    rst_n        = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_ctrl", {60'd0, bus.rx_ready, bus.tx_valid, busy, 1'b0}, {60'd0, 4'b1000});
    check("rst_tx_data", {56'd0, bus.tx_data}, 64'd0);
    check("rst_dc", {bus.dc_a2, bus.dc_wd2}, 64'd0);
    check("rst_ic", {bus.ic_a2, bus.ic_wd2}, 64'd0);
    check("rst_we2", {56'd0, bus.dc_we2, bus.ic_we2}, 64'd0);
    @(posedge clk); #1;

    // Single data-cache write
    exp_wr.push_back('{ic: 1'b0, a: 32'h0000_1000, d: 32'h1234_5678});
    exp_tx.push_back(8'hA5);
    send_byte(8'h01); send_word(32'h0000_1000); send_word(32'h1234_5678);
    wait_idle("idle_write");

    // Single instruction-cache read
    push_word(32'hDEAD_BEEF);
    send_byte(8'h02); send_word(32'h0000_0040);
    wait_idle("idle_read");
    check("a2_hold", {bus.dc_a2, bus.ic_a2}, {32'h0000_1000, 32'h0000_0040});
    check("wd2_hold", {32'd0, bus.dc_wd2}, {32'd0, 32'h1234_5678});

    // Read with backpressure on the third response byte
    bus.tx_ready = 1'b0;
    w = dc_model(32'h0000_0100);
    push_word(w);
    send_byte(8'h00); send_word(32'h0000_0100);
    take_byte(0, w[7:0]);
    take_byte(0, w[15:8]);
    take_byte(5, w[23:16]);
    take_byte(0, w[31:24]);
    bus.tx_ready = 1'b1;
    wait_idle("idle_backpressure");

    // Illegal opcode, then an instruction-cache write
    exp_tx.push_back(8'hEE);
    send_byte(8'h0C);
    wait_idle("idle_illegal");
    exp_wr.push_back('{ic: 1'b1, a: 32'h0000_0080, d: 32'h0BAD_F00D});
    exp_tx.push_back(8'hA5);
    send_byte(8'h03); send_word(32'h0000_0080); send_word(32'h0BAD_F00D);
    wait_idle("idle_ic_write");

    // Inter-byte timeout abandons a partial frame
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h30);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("timeout_idle", {62'd0, busy, bus.rx_ready}, {62'd0, 1'b0, 1'b1});
    @(posedge clk); #1;
    exp_wr.push_back('{ic: 1'b0, a: 32'h0000_2000, d: 32'hCAFE_F00D});
    exp_tx.push_back(8'hA5);
    send_byte(8'h01); send_word(32'h0000_2000); send_word(32'hCAFE_F00D);
    wait_idle("idle_after_timeout");

    // Asynchronous reset while the write strobe is high
    exp_wr.push_back('{ic: 1'b0, a: 32'h0000_3000, d: 32'h55AA_55AA});
    send_byte(8'h01); send_word(32'h0000_3000); send_word(32'h55AA_55AA);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.dc_we2 != 4'h0) begin seen = 1'b1; break; end
    end
    check("rst_wr_seen", {63'd0, seen}, 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_wr_we2", {56'd0, bus.dc_we2, bus.ic_we2}, 64'd0);
    check("rst_wr_ctrl", {62'd0, bus.tx_valid, busy}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Burst opcode 0x30: four-word data read, or illegal without burst support
`ifdef DEBUG_MEM_BURST_EN
    push_word(dc_model(32'hFFFF_FFF8));
    push_word(dc_model(32'hFFFF_FFFC));
    push_word(dc_model(32'h0000_0000));
    push_word(dc_model(32'h0000_0004));
    send_byte(8'h30); send_word(32'hFFFF_FFF8);
`else
    exp_tx.push_back(8'hEE);
    send_byte(8'h30);
`endif
    wait_idle("idle_burst_opcode");

    check("queues_drained", {32'(exp_tx.size()), 32'(exp_wr.size())}, 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
